perceptron_stream_responder: RTL and testbench
==============================================

// Module: perceptron_stream_responder
// PURPOSE
//   Receiving end of the weight/data streaming interface that the bagging
//   bench drives.
//   - Write phase: captures N_FEAT signed weights into a local register file,
//     indexed by address.
//   - Read phase: consumes one binary feature per cycle, accumulates the dot
//     product plus bias, and emits a +1/-1 prediction with a one-cycle ready
//     pulse.
//   - One instance per bagging lane; the vote logic sits downstream.
// PARAMETERS
//   N_FEAT  30  features/weights per sample
//   W_W     9   signed weight and bias width
//   A_W     5   address width (2**A_W >= N_FEAT)
//   ACC_W   16  signed accumulator width (>= W_W+clog2(N_FEAT+1)+1)
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous reset, active low
//   write    in   1      write phase: weight valid on this cycle
//   en       in   1      read phase: data bit valid on this cycle
//   address  in   A_W    weight index (write) or feature index (read)
//   weight   in   W_W    signed weight, sampled when write=1
//   data     in   2      signed feature; only bit0 used (0 or 1)
//   bias     in   W_W    signed bias, sampled on the cycle of the last feature
//   loaded   out  1      all N_FEAT weights received since reset/last load
//   busy     out  1      accumulation in progress
//   ready    out  1      one-cycle pulse: predict valid
//   predict  out  2      signed result: 2'b01 (+1) or 2'b11 (-1)
//   flag     out  1      sticky protocol error; cleared only by rst=0
// BEHAVIOUR
//   Reset (rst=0 at posedge)
//   - All outputs 0, state IDLE, acc=0, load mask=0.
//   - Weight RAM contents are don't-care; loaded=0 makes them unusable.
//   States: IDLE, LOAD, ARMED, ACCUM, RESULT.
//   IDLE
//   - write=1: go to LOAD and store this cycle's weight.
//   - en=1: set flag, stay in IDLE.
//   LOAD
//   - Each write=1 cycle: wmem[address]<=weight; mask[address]<=1.
//   - address >= N_FEAT: ignore the write, set flag.
//   - Rewriting an address: overwrite the weight, no error.
//   - write falls with mask all ones: loaded<=1 and go to ARMED.
//   - write falls with mask not full: set flag, clear mask, go to IDLE.
//   ARMED
//   - en=1 with address==0: go to ACCUM and process this bit.
//   - en=1 with address!=0: set flag, stay in ARMED.
//   - write=1: new load; loaded<=0, mask cleared, go to LOAD, store weight.
//   ACCUM
//   - busy=1. Per en=1 cycle: acc <= acc + (data[0] ? sext(wmem[address]) : 0).
//   - Expected address increments by 1 each en cycle. A mismatch sets flag,
//     clears acc and returns to ARMED.
//   - en=0 cycles are stalls: hold acc and the expected address.
//   - en=1 with address==N_FEAT-1: add the last term, then add sext(bias)
//     in the same cycle, and go to RESULT.
//   - write=1 in ACCUM: abort the sample (acc=0), set flag, restart LOAD.
//     write has priority when write and en are both high.
//   RESULT (one cycle)
//   - ready=1 and busy=0.
//   - predict = (acc >= 0) ? +1 : -1; zero counts as +1.
//   - predict holds until the next RESULT.
//   - acc cleared, go to ARMED. en=1 with address==0 in this cycle is
//     accepted as the first bit of the next sample (back-to-back).
//   Timing
//   - Latency: ready is asserted the cycle after the last feature is sampled.
//   - Arithmetic: full-precision signed throughout; no saturation is needed
//     at the default widths.
//   - Reset mid-operation aborts everything: outputs return to their reset
//     values and loaded=0.
// TESTING
//   1 Load 30 weights all 9'h1C1 (-63), bias -255, data all ones
//     -> acc=-2145, ready pulse 1 cycle later, predict=-1.
//   2 Load weight[i]=+10, bias=-255, data=30'h3FFFFFFF
//     -> 300-255=45, predict=+1.
//     Then data=0 -> acc=-255, predict=-1.
//   3 Sum+bias exactly 0 (weights +17 on 15 ones, bias -255)
//     -> predict=+1.
//   4 write drops after 20 weights -> flag=1, loaded=0.
//     A following en stream -> no ready.
//   5 Feature stream 0..12, en low 5 cycles, resume 13..29
//     -> same predict as the unstalled stream.
//     Skip address 14 -> flag=1, no ready.
//   6 rst=0 during ACCUM
//     -> ready/busy/loaded/flag=0 next cycle.
//     Reload and rerun case 1 -> correct result.

Source files
------------

// File: rtl/perceptron_stream_responder.sv
// perceptron_stream_responder
//   Receiving end of the weight/data streaming interface for one bagging lane.
//   A write phase fills a local weight register file; a read phase streams one
//   binary feature per cycle, accumulates the dot product plus bias and emits a
//   +1/-1 prediction with a one-cycle ready pulse.
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active low
//   write    weight valid this cycle (write phase)
//   en       feature bit valid this cycle (read phase)
//   address  weight index (write) or feature index (read)
//   weight   signed weight, sampled when write=1
//   data     signed feature, only bit 0 is used
//   bias     signed bias, sampled with the last feature
//   loaded   all N_FEAT weights received since reset/last load
//   busy     accumulation in progress
//   ready    one-cycle pulse, predict valid
//   predict  2'b01 (+1) or 2'b11 (-1), held until the next result
//   flag     sticky protocol error, cleared only by reset
module perceptron_stream_responder #(
    parameter int unsigned N_FEAT = 30,
    parameter int unsigned W_W    = 9,
    parameter int unsigned A_W    = 5,
    parameter int unsigned ACC_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic                  en,
    input  logic [A_W-1:0]        address,
    input  logic signed [W_W-1:0] weight,
    input  logic signed [1:0]     data,
    input  logic signed [W_W-1:0] bias,
    output logic                  loaded,
    output logic                  busy,
    output logic                  ready,
    output logic [1:0]            predict,
    output logic                  flag
);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, ACCUM, RESULT} state_t;

    state_t                  state;
    logic signed [W_W-1:0]   wmem [N_FEAT];
    logic [N_FEAT-1:0]       mask;
    logic [N_FEAT-1:0]       mask_next;
    logic [A_W-1:0]          expect_addr;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_final;
    logic                    in_range;
    logic                    last;
    logic                    bit_ok;
    logic                    unused_data;

    assign unused_data = data[1];

    always_comb begin
        in_range  = ({1'b0, address} < (A_W+1)'(N_FEAT));
        last      = (address == A_W'(N_FEAT - 1));
        // First bit of a sample (ARMED/RESULT) must be index 0.
        bit_ok    = (state == ACCUM) ? (address == expect_addr) : (address == '0);
        term      = '0;
        if (in_range && data[0]) begin
            term = ACC_W'(wmem[address]);
        end
        acc_base  = (state == ACCUM) ? acc : '0;
        acc_sum   = acc_base + term;
        acc_final = acc_sum + ACC_W'(bias);
        // Any write outside LOAD starts a fresh load with an empty mask.
        mask_next = (state == LOAD) ? mask : '0;
        if (in_range) begin
            mask_next[address] = 1'b1;
        end
    end

    // Weight storage carries no reset; loaded=0 guards stale contents.
    always_ff @(posedge clk) begin
        if (write && in_range) begin
            wmem[address] <= weight;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            acc         <= '0;
            mask        <= '0;
            expect_addr <= '0;
            loaded      <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            predict     <= '0;
            flag        <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (write) begin
                mask <= mask_next;
                if (!in_range) begin
                    flag <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (write) begin
                        state <= LOAD;
                    end else if (en) begin
                        flag <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!write) begin
                        if (&mask) begin
                            loaded <= 1'b1;
                            state  <= ARMED;
                        end else begin
                            flag  <= 1'b1;
                            mask  <= '0;
                            state <= IDLE;
                        end
                    end
                end
                ARMED, RESULT, ACCUM: begin
                    if (write) begin
                        if (state == ACCUM) begin
                            flag <= 1'b1;
                        end
                        loaded <= 1'b0;
                        busy   <= 1'b0;
                        acc    <= '0;
                        state  <= LOAD;
                    end else if (en) begin
                        if (!bit_ok) begin
                            flag  <= 1'b1;
                            busy  <= 1'b0;
                            acc   <= '0;
                            state <= ARMED;
                        end else if (last) begin
                            predict <= (acc_final >= 0) ? 2'b01 : 2'b11;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            acc     <= '0;
                            state   <= RESULT;
                        end else begin
                            acc         <= acc_sum;
                            expect_addr <= address + 1'b1;
                            busy        <= 1'b1;
                            state       <= ACCUM;
                        end
                    end else if (state != ACCUM) begin
                        acc   <= '0;
                        state <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_stream_responder.sv
// tb_perceptron_stream_responder
//   Scenario tasks driving perceptron_stream_responder, checked against a
//   plain-integer dot-product model of the expected prediction.
module tb_perceptron_stream_responder;

    localparam int N = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic              write;
    logic              en;
    logic [4:0]        address;
    logic signed [8:0] weight;
    logic signed [1:0] data;
    logic signed [8:0] bias;
    logic              loaded;
    logic              busy;
    logic              ready;
    logic [1:0]        predict;
    logic              flag;

    int total = 0;
    int bad   = 0;
    int ref_w [N];

    perceptron_stream_responder #(
        .N_FEAT(30),
        .W_W   (9),
        .A_W   (5),
        .ACC_W (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .write  (write),
        .en     (en),
        .address(address),
        .weight (weight),
        .data   (data),
        .bias   (bias),
        .loaded (loaded),
        .busy   (busy),
        .ready  (ready),
        .predict(predict),
        .flag   (flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_sum(input logic [N-1:0] bits, input int b);
        int s = b;
        for (int i = 0; i < N; i++) begin
            if (bits[i]) s += ref_w[i];
        end
        return s;
    endfunction

    function automatic logic [1:0] ref_pred(input int s);
        return (s >= 0) ? 2'b01 : 2'b11;
    endfunction

    function automatic int rand_s9();
        return int'($urandom_range(511)) - 256;
    endfunction

    task automatic do_reset();
        rst = 1'b0; write = 1'b0; en = 1'b0;
        address = '0; weight = '0; data = '0; bias = '0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic set_weights(input int v);
        for (int i = 0; i < N; i++) ref_w[i] = v;
    endtask

    task automatic rand_weights();
        for (int i = 0; i < N; i++) ref_w[i] = rand_s9();
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            write = 1'b1; address = 5'(i); weight = 9'(ref_w[i]);
            tick();
        end
        write = 1'b0;
        tick();
    endtask

    // Streams one sample; returns in the RESULT cycle with inputs idle.
    task automatic run_sample(input logic [N-1:0] bits, input int b,
                              input int stall_at, input int stall_len, input string tag);
        logic [1:0] exp;
        exp = ref_pred(ref_sum(bits, b));
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    en = 1'b0; data = '0;
                    tick();
                    total++;
                    if (ready !== 1'b0 || busy !== 1'b1) begin
                        bad++;
                        $display("FAIL %s_stall: ready=%b busy=%b want ready=0 busy=1", tag, ready, busy);
                    end
                end
            end
            en = 1'b1; address = 5'(i); data = {1'b0, bits[i]};
            bias = (i == N - 1) ? 9'(b) : 9'($urandom);
            tick();
            if (i == 0) begin
                total++;
                if (busy !== 1'b1 || ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_first: busy=%b ready=%b want busy=1 ready=0", tag, busy, ready);
                end
            end
        end
        en = 1'b0; data = '0;
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || predict !== exp) begin
            bad++;
            $display("FAIL %s_result: ready=%b busy=%b predict=%b want ready=1 busy=0 predict=%b",
                     tag, ready, busy, predict, exp);
        end
    endtask

    task automatic check_hold(input logic [1:0] exp, input string tag);
        tick();
        total++;
        if (ready !== 1'b0 || predict !== exp) begin
            bad++;
            $display("FAIL %s_hold: ready=%b predict=%b want ready=0 predict=%b", tag, ready, predict, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({loaded, busy, ready, flag, predict} !== 6'b0) begin
            bad++;
            $display("FAIL reset: loaded=%b busy=%b ready=%b flag=%b predict=%b want all 0",
                     loaded, busy, ready, flag, predict);
        end
    endtask

    task automatic test_all_negative();
        set_weights(-63);
        load_all();
        total++;
        if (loaded !== 1'b1 || flag !== 1'b0) begin
            bad++;
            $display("FAIL neg_load: loaded=%b flag=%b want loaded=1 flag=0", loaded, flag);
        end
        run_sample('1, -255, -1, 0, "neg");
        check_hold(2'b11, "neg");
    endtask

    task automatic test_positive();
        set_weights(10);
        load_all();
        run_sample('1, -255, -1, 0, "pos_ones");
        check_hold(2'b01, "pos_ones");
        run_sample('0, -255, -1, 0, "pos_zeros");
        check_hold(2'b11, "pos_zeros");
    endtask

    task automatic test_zero_sum();
        set_weights(17);
        load_all();
        run_sample(30'h00007FFF, -255, -1, 0, "zero");
        check_hold(2'b01, "zero");
    endtask

    task automatic test_stall_and_skip();
        logic [N-1:0] bits;
        int b;
        int pulses;
        do_reset();
        rand_weights();
        load_all();
        bits = N'($urandom);
        b = rand_s9();
        run_sample(bits, b, 13, 5, "stalled");
        check_hold(ref_pred(ref_sum(bits, b)), "stalled");
        run_sample(bits, b, -1, 0, "unstalled");
        check_hold(ref_pred(ref_sum(bits, b)), "unstalled");
        total++;
        if (flag !== 1'b0) begin
            bad++;
            $display("FAIL stall_flag: flag=%b want 0", flag);
        end
        pulses = 0;
        for (int i = 0; i < N; i++) begin
            if (i == 14) continue;
            en = 1'b1; address = 5'(i); data = {1'b0, bits[i]}; bias = 9'(b);
            tick();
            if (ready === 1'b1) pulses++;
        end
        en = 1'b0;
        tick();
        if (ready === 1'b1) pulses++;
        total++;
        if (flag !== 1'b1 || pulses !== 0) begin
            bad++;
            $display("FAIL skip: flag=%b pulses=%0d want flag=1 pulses=0", flag, pulses);
        end
    endtask

    task automatic test_short_load();
        int pulses;
        do_reset();
        rand_weights();
        for (int i = 0; i < 20; i++) begin
            write = 1'b1; address = 5'(i); weight = 9'(ref_w[i]);
            tick();
        end
        write = 1'b0;
        tick();
        total++;
        if (flag !== 1'b1 || loaded !== 1'b0) begin
            bad++;
            $display("FAIL short_load: flag=%b loaded=%b want flag=1 loaded=0", flag, loaded);
        end
        pulses = 0;
        for (int i = 0; i < N; i++) begin
            en = 1'b1; address = 5'(i); data = 2'b01;
            tick();
            if (ready === 1'b1) pulses++;
        end
        en = 1'b0;
        tick();
        if (ready === 1'b1) pulses++;
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL short_stream: pulses=%0d want 0", pulses);
        end
    endtask

    task automatic test_abort();
        logic [N-1:0] bits;
        int b;
        do_reset();
        rand_weights();
        load_all();
        for (int i = 0; i < 10; i++) begin
            en = 1'b1; address = 5'(i); data = 2'b01;
            tick();
        end
        en = 1'b0;
        total++;
        if (flag !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: flag=%b busy=%b want flag=0 busy=1", flag, busy);
        end
        rand_weights();
        load_all();
        total++;
        if (flag !== 1'b1 || loaded !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_reload: flag=%b loaded=%b busy=%b want 1 1 0", flag, loaded, busy);
        end
        bits = N'($urandom);
        b = rand_s9();
        run_sample(bits, b, -1, 0, "abort_sample");
        check_hold(ref_pred(ref_sum(bits, b)), "abort_sample");
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] bits;
        int b;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            rand_weights();
            load_all();
            for (int s = 0; s < 5; s++) begin
                bits = N'($urandom);
                b = rand_s9();
                if (($urandom & 1) != 0)
                    run_sample(bits, b, int'($urandom_range(N - 1, 1)), int'($urandom_range(4, 1)), "b2b");
                else
                    run_sample(bits, b, -1, 0, "b2b");
            end
            check_hold(ref_pred(ref_sum(bits, b)), "b2b");
        end
    endtask

    task automatic test_mid_reset();
        set_weights(-63);
        load_all();
        for (int i = 0; i < 11; i++) begin
            en = 1'b1; address = 5'(i); data = 2'b01;
            tick();
        end
        en = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if ({loaded, busy, ready, flag, predict} !== 6'b0) begin
            bad++;
            $display("FAIL mid_reset: loaded=%b busy=%b ready=%b flag=%b predict=%b want all 0",
                     loaded, busy, ready, flag, predict);
        end
        load_all();
        run_sample('1, -255, -1, 0, "rerun");
        check_hold(2'b11, "rerun");
    endtask

    initial begin
        test_reset();
        test_all_negative();
        test_positive();
        test_zero_sum();
        test_stall_and_skip();
        test_short_load();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
